// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM ramp sequencer.
// Data width, FSM state encoding, and the duty-stepping arithmetic.
package pwm_pkg;

   localparam int unsigned PWM_W = 32;

   typedef enum logic [0:0] {IDLE, RAMP} state_e;

   // Move cur toward tgt by step; land exactly on tgt instead of overshooting.
   // A step of 0 jumps straight to tgt.
   function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] cur,
                                                    input logic [PWM_W-1:0] tgt,
                                                    input logic [PWM_W-1:0] step);
      logic [PWM_W-1:0] res;
      if (step == '0) begin
         res = tgt;
      end else if (cur < tgt) begin
         res = ((tgt - cur) <= step) ? tgt : cur + step;
      end else begin
         res = ((cur - tgt) <= step) ? tgt : cur - step;
      end
      return res;
   endfunction

   // Limit the duty to the period length (ftw+1). The compare is done in 33 bits so that
   // ftw=all-ones does not wrap. The result never exceeds duty, so it always fits in 32 bits.
   function automatic logic [PWM_W-1:0] clamp_duty(input logic [PWM_W-1:0] duty,
                                                   input logic [PWM_W-1:0] ftw);
      logic [PWM_W:0] lim;
      lim = {1'b0, ftw} + {{PWM_W{1'b0}}, 1'b1};
      return ({1'b0, duty} < lim) ? duty : lim[PWM_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_phase_tracker.sv
// Mirror of the pwm_ctrl period counter; flags the last clock of each PWM period.
// The counter stays in lock-step with pwm_ctrl because both reset together and only see our loads.
module pwm_phase_tracker
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PWM_W-1:0] ftw_cur,
   input  logic             load,
   output logic [PWM_W-1:0] ph_cnt,
   output logic             boundary
);

   assign boundary = (ph_cnt == ftw_cur);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt <= '0;
      end else if (load || (ph_cnt >= ftw_cur)) begin
         ph_cnt <= '0;
      end else begin
         ph_cnt <= ph_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_ramp_sched.sv
// Soft-start/soft-stop sequencer for pwm_ctrl: steps the duty once per PWM period
// and issues loads only on period boundaries.
module pwm_ramp_sched
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [PWM_W-1:0] cmd_ftw,
   input  logic [PWM_W-1:0] cmd_duty,
   input  logic [PWM_W-1:0] cmd_step,
   input  logic             stop,
   output logic [PWM_W-1:0] pwm_ftw,
   output logic [PWM_W-1:0] pwm_duty,
   output logic             pwm_load,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   logic [PWM_W-1:0] ftw_cur_q, duty_cur_q, target_q, step_q, ftw_new_q;
   logic             done_q;
   logic [PWM_W-1:0] ph_cnt, duty_nxt, exit_tgt;
   logic             boundary, load_now;

   pwm_phase_tracker u_phase (
      .clk      (clk),
      .rst_n    (rst_n),
      .ftw_cur  (ftw_cur_q),
      .load     (load_now),
      .ph_cnt   (ph_cnt),
      .boundary (boundary)
   );

   // Load decode uses registered state only, so there is no input-to-pwm path.
   assign load_now = (state_q == RAMP) && boundary;
   assign duty_nxt = step_toward(duty_cur_q, target_q, step_q);
   // A stop arriving on a load cycle retargets to 0, so finishing at the old target is not done.
   assign exit_tgt = stop ? '0 : target_q;

   assign pwm_load  = load_now;
   assign pwm_ftw   = load_now ? ftw_new_q : ftw_cur_q;
   assign pwm_duty  = load_now ? duty_nxt : duty_cur_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign cmd_ready = (state_q == IDLE) && !stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ftw_cur_q  <= '0;
         duty_cur_q <= '0;
         target_q   <= '0;
         step_q     <= '0;
         ftw_new_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (stop) begin
                  if (duty_cur_q != '0) begin
                     target_q  <= '0;
                     ftw_new_q <= ftw_cur_q;
                     state_q   <= RAMP;
                  end
               end else if (cmd_valid) begin
                  ftw_new_q <= cmd_ftw;
                  step_q    <= cmd_step;
                  target_q  <= clamp_duty(cmd_duty, cmd_ftw);
                  state_q   <= RAMP;
               end
            end
            RAMP: begin
               if (stop) begin
                  target_q <= '0;
               end
               if (load_now) begin
                  ftw_cur_q  <= ftw_new_q;
                  duty_cur_q <= duty_nxt;
                  if (duty_nxt == exit_tgt) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
